// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and flags build mismatches.
// Optional periodic re-check is enabled by defining SYSID_BOOT_CHECKER_PERIODIC_EN.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1423087687,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT        = 255,
    parameter bit          AUTO_START     = 1'b1
`ifdef SYSID_BOOT_CHECKER_PERIODIC_EN
    ,
    parameter int          RECHECK_PERIOD = 1000000
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam bit          LAT_ZERO  = (READ_LATENCY == 32'sd0);
    localparam logic [1:0]  LAT_LOAD  = LAT_ZERO ? 2'd0 : 2'(READ_LATENCY - 32'sd1);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 32'sd1);

    state_t      state_r;
    state_t      state_s;
    logic        busy_r;
    logic        done_r;
    logic        id_ok_r;
    logic        ts_ok_r;
    logic        timeout_r;
    logic [31:0] id_value_r;
    logic [31:0] ts_value_r;
    logic        avm_address_r;
    logic        avm_read_r;
    logic        auto_pend_r;
    logic [1:0]  lat_cnt_r;
    logic [15:0] wait_cnt_r;

    logic        go_s;
    logic        per_hit_s;
    logic        wait_hit_s;
    logic        accept_s;
    logic        cap_id_s;
    logic        cap_ts_s;
    logic        abort_s;
    logic        enter_s;
    logic [31:0] ts_cmp_s;

    assign busy        = busy_r;
    assign done        = done_r;
    assign id_ok       = id_ok_r;
    assign ts_ok       = ts_ok_r;
    assign timeout     = timeout_r;
    assign id_value    = id_value_r;
    assign ts_value    = ts_value_r;
    assign avm_address = avm_address_r;
    assign avm_read    = avm_read_r;

`ifdef SYSID_BOOT_CHECKER_PERIODIC_EN
    localparam logic [31:0] PER_LAST = 32'(RECHECK_PERIOD - 32'sd1);
    logic [31:0] per_cnt_r;

    // Idle-time counter that triggers a periodic re-check; cleared whenever a check starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            per_cnt_r <= 32'd0;
        end else if (state_r == IDLE && state_s == RD_ID) begin
            per_cnt_r <= 32'd0;
        end else if (state_r == IDLE) begin
            per_cnt_r <= per_cnt_r + 32'd1;
        end else begin
            per_cnt_r <= per_cnt_r;
        end
    end

    assign per_hit_s = (state_r == IDLE) && (per_cnt_r == PER_LAST);
`else
    assign per_hit_s = 1'b0;
`endif

    // Decode of handshake, capture strobes and the completion compare.
    always_comb begin
        go_s       = start || auto_pend_r || per_hit_s;
        wait_hit_s = (wait_cnt_r == WAIT_LAST);
        accept_s   = avm_read_r && !avm_waitrequest;
        abort_s    = 1'b0;
        cap_id_s   = 1'b0;
        cap_ts_s   = 1'b0;
        if (state_r == RD_ID || state_r == RD_TS) begin
            abort_s = avm_waitrequest && wait_hit_s;
        end else begin
            abort_s = 1'b0;
        end
        if (state_r == RD_ID) begin
            cap_id_s = LAT_ZERO && accept_s;
        end else if (state_r == LAT_ID) begin
            cap_id_s = (lat_cnt_r == 2'd0);
        end else begin
            cap_id_s = 1'b0;
        end
        if (state_r == RD_TS) begin
            cap_ts_s = LAT_ZERO && accept_s;
        end else if (state_r == LAT_TS) begin
            cap_ts_s = (lat_cnt_r == 2'd0);
        end else begin
            cap_ts_s = 1'b0;
        end
        // With zero latency the timestamp arrives on the same edge that enters FIN.
        if (cap_ts_s) begin
            ts_cmp_s = avm_readdata;
        end else begin
            ts_cmp_s = ts_value_r;
        end
        enter_s = (state_s != state_r);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (go_s) begin
                    state_s = RD_ID;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    state_s = LAT_ZERO ? RD_TS : LAT_ID;
                end else if (wait_hit_s) begin
                    state_s = FIN;
                end else begin
                    state_s = RD_ID;
                end
            end
            LAT_ID: begin
                if (lat_cnt_r == 2'd0) begin
                    state_s = RD_TS;
                end else begin
                    state_s = LAT_ID;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    state_s = LAT_ZERO ? FIN : LAT_TS;
                end else if (wait_hit_s) begin
                    state_s = FIN;
                end else begin
                    state_s = RD_TS;
                end
            end
            LAT_TS: begin
                if (lat_cnt_r == 2'd0) begin
                    state_s = FIN;
                end else begin
                    state_s = LAT_TS;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Read-wait and latency counters; both restart on every state change.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_r <= 16'd0;
            lat_cnt_r  <= 2'd0;
        end else begin
            if (enter_s) begin
                wait_cnt_r <= 16'd0;
            end else if (avm_read_r && avm_waitrequest) begin
                wait_cnt_r <= wait_cnt_r + 16'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (enter_s && (state_s == LAT_ID || state_s == LAT_TS)) begin
                lat_cnt_r <= LAT_LOAD;
            end else if (lat_cnt_r != 2'd0) begin
                lat_cnt_r <= lat_cnt_r - 2'd1;
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end
        end
    end

    // Bus strobes and status flags, all registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            auto_pend_r   <= AUTO_START;
            avm_read_r    <= 1'b0;
            avm_address_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            id_ok_r       <= 1'b0;
            ts_ok_r       <= 1'b0;
            timeout_r     <= 1'b0;
            id_value_r    <= 32'd0;
            ts_value_r    <= 32'd0;
        end else begin
            auto_pend_r   <= 1'b0;
            avm_read_r    <= (state_s == RD_ID) || (state_s == RD_TS);
            avm_address_r <= (state_s == RD_TS) || (state_s == LAT_TS);
            busy_r        <= (state_s != IDLE) && (state_s != FIN);
            done_r        <= (state_s == FIN);
            if (cap_id_s) begin
                id_value_r <= avm_readdata;
            end else begin
                id_value_r <= id_value_r;
            end
            if (cap_ts_s) begin
                ts_value_r <= avm_readdata;
            end else begin
                ts_value_r <= ts_value_r;
            end
            if (state_r == IDLE && state_s == RD_ID) begin
                id_ok_r   <= 1'b0;
                ts_ok_r   <= 1'b0;
                timeout_r <= 1'b0;
            end else if (enter_s && state_s == FIN) begin
                id_ok_r   <= !abort_s && (id_value_r == EXPECTED_ID);
                ts_ok_r   <= !abort_s && (ts_cmp_s == EXPECTED_TS);
                timeout_r <= abort_s;
            end else begin
                id_ok_r   <= id_ok_r;
                ts_ok_r   <= ts_ok_r;
                timeout_r <= timeout_r;
            end
        end
    end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sits directly downstream of the system-ID slave and consumes its two words: ID at address 0, build timestamp at address 1.
- Reads both words after reset or on request and compares them against build-time expected values.
- Drives pass/fail status that gates the rest of the system; a mismatched FPGA image or software build is flagged in hardware.

Parameters:
- EXPECTED_ID, 32'd0, expected word at sysid address 0.
- EXPECTED_TS, 32'd1423087687, expected timestamp word at sysid address 1.
- READ_LATENCY, 0, cycles from accepted read (waitrequest low) to valid readdata; legal range 0..3.
- TIMEOUT, 255, maximum cycles a single read may be held off by waitrequest before abort; legal range 1..65535.
- AUTO_START, 1, when 1 a check starts automatically in the first cycle after reset deasserts.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run a check.
- busy  out  1  high while a check is in progress.
- done  out  1  one-cycle pulse when a check completes, pass or fail.
- id_ok  out  1  last captured ID equals EXPECTED_ID.
- ts_ok  out  1  last captured timestamp equals EXPECTED_TS.
- timeout  out  1  last check aborted on waitrequest timeout.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.
- avm_address  out  1  word address to the sysid slave.
- avm_read  out  1  read strobe.
- avm_readdata  in  32  read data from the sysid slave.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Clock/reset: one clock named clock; reset is synchronous and active-high, named reset.
- Reset values: all outputs 0, avm_address 0, FSM in IDLE. Reset mid-check aborts immediately; no done pulse is issued.
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN.
  - IDLE -> RD_ID on start, or on the first cycle after reset when AUTO_START=1. Entering RD_ID clears id_ok, ts_ok and timeout and sets busy.
  - RD_ID: avm_read=1, avm_address=0, both held stable until avm_waitrequest=0 (accept).
    - On accept with READ_LATENCY=0: capture avm_readdata into id_value in the same cycle and go to RD_TS.
    - On accept with READ_LATENCY>0: go to LAT_ID, load the latency counter, deassert avm_read.
  - LAT_ID: count down READ_LATENCY cycles; capture on the final cycle (exactly READ_LATENCY cycles after accept), then go to RD_TS.
  - RD_TS and LAT_TS: identical to RD_ID and LAT_ID with avm_address=1, capturing into ts_value.
  - FIN: single cycle. busy=0, done=1. id_ok and ts_ok are registered from the 32-bit equality compares. Return to IDLE.
- Timeout: a wait counter resets on each new read and increments each cycle avm_read=1 and avm_waitrequest=1.
  - When the count reaches TIMEOUT, drop avm_read, set timeout=1, go to FIN.
  - id_ok and ts_ok are 0 for any check that timed out; the value of the unread word is left unchanged.
- avm_read is never asserted outside RD_ID/RD_TS; only one read is outstanding at a time.
- start while busy=1 is ignored and is not queued. start in the same cycle as FIN is ignored.
- Status outputs hold their values until the next check starts.

Optional Feature:
- Macro SYSID_BOOT_CHECKER_PERIODIC_EN.
- Defined: adds parameter RECHECK_PERIOD (default 1000000) and a free-running counter active in IDLE that auto-starts a check every RECHECK_PERIOD cycles. The counter resets on every check start. Explicit start still works.
- Undefined: checks run only at reset (AUTO_START) or on start; no period counter is synthesized.

Test Plan:
- Nominal: slave returns 0 at addr 0 and 1423087687 at addr 1, waitrequest=0, READ_LATENCY=0, AUTO_START=1 -> done pulses 3 cycles after reset release; id_ok=1, ts_ok=1, timeout=0.
- Timestamp mismatch: addr 1 returns 1423087688 -> id_ok=1, ts_ok=0, ts_value=1423087688, done pulses once.
- Stall and latency: READ_LATENCY=2, waitrequest high for 3 cycles on each read -> address/read stable during stall; data sampled exactly 2 cycles after accept; both ok flags set.
- Timeout: TIMEOUT=8, waitrequest stuck high on the ID read -> avm_read drops after 8 stall cycles; timeout=1, id_ok=0, ts_ok=0; the timestamp read is never issued.
- Control: start pulsed while busy -> ignored, one done only. reset asserted during LAT_TS -> all outputs 0 next cycle, no done; with AUTO_START=1 a fresh check runs after release.
- With SYSID_BOOT_CHECKER_PERIODIC_EN, RECHECK_PERIOD=50 -> done pulses recur with a spacing of exactly 50 cycles plus the check length.
